// File: rtl/rob_commit_if.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_if
// Purpose  : Bundles the reorder buffer's dispatch, completion, flush and
//            commit-side signals into one port.
// Ports    : dispatch  - disp_v_i, disp_ready_o, disp_old_phys_v_i,
//                        disp_old_phys_i, disp_flag_mask_i, disp_tag_o
//            complete  - cmp_v_i, cmp_tag_i, cmp_flags_i (flattened per FU)
//            control   - flush_i
//            commit    - rob_phys_valid_o, rob_phys_reg_cl_o,
//                        rob_flag_valid_o, rob_flag_o, commit_v_o,
//                        commit_tag_o, rob_count_o
// Modports : slave  - the reorder buffer itself
//            master - dispatch / execute / architectural-state side
// Revision : 1.0 - initial release
// ============================================================================
interface rob_commit_if #(
    parameter int ROB_DEPTH    = 16,
    parameter int NUM_FU       = 2,
    parameter int NUM_PHYS_REG = 128,
    parameter int NUM_FLAGS    = 4
);
    localparam int TAG_W  = $clog2(ROB_DEPTH);
    localparam int PHYS_W = $clog2(NUM_PHYS_REG);

    logic                        disp_v_i;
    logic                        disp_ready_o;
    logic                        disp_old_phys_v_i;
    logic [PHYS_W-1:0]           disp_old_phys_i;
    logic [NUM_FLAGS-1:0]        disp_flag_mask_i;
    logic [TAG_W-1:0]            disp_tag_o;
    logic [NUM_FU-1:0]           cmp_v_i;
    logic [NUM_FU*TAG_W-1:0]     cmp_tag_i;
    logic [NUM_FU*NUM_FLAGS-1:0] cmp_flags_i;
    logic                        flush_i;
    logic                        rob_phys_valid_o;
    logic [PHYS_W-1:0]           rob_phys_reg_cl_o;
    logic                        rob_flag_valid_o;
    logic [2*NUM_FLAGS-1:0]      rob_flag_o;
    logic                        commit_v_o;
    logic [TAG_W-1:0]            commit_tag_o;
    logic [TAG_W:0]              rob_count_o;

    modport slave (
        input  disp_v_i, disp_old_phys_v_i, disp_old_phys_i, disp_flag_mask_i,
        input  cmp_v_i, cmp_tag_i, cmp_flags_i, flush_i,
        output disp_ready_o, disp_tag_o,
        output rob_phys_valid_o, rob_phys_reg_cl_o, rob_flag_valid_o, rob_flag_o,
        output commit_v_o, commit_tag_o, rob_count_o
    );

    modport master (
        output disp_v_i, disp_old_phys_v_i, disp_old_phys_i, disp_flag_mask_i,
        output cmp_v_i, cmp_tag_i, cmp_flags_i, flush_i,
        input  disp_ready_o, disp_tag_o,
        input  rob_phys_valid_o, rob_phys_reg_cl_o, rob_flag_valid_o, rob_flag_o,
        input  commit_v_o, commit_tag_o, rob_count_o
    );
endinterface
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit
// Purpose  : Reorder buffer with in-order commit. Allocates one entry per
//            dispatch, records execute completions and their flag results,
//            and retires the oldest finished entry each cycle, freeing its
//            superseded physical register and emitting a masked flag write.
// Ports    : clk_i     - clock, all state updates on the rising edge
//            reset_n_i - synchronous active-low reset
//            rob       - rob_commit_if.slave (dispatch, completion, flush,
//                        commit / architectural-state outputs)
// Config   : `define ROB_CMP_BYPASS_EN lets a completion hitting the head
//            entry retire it in the same cycle (flags taken from the
//            completing port). Undefined: commit uses registered done bits.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit #(
    parameter int ROB_DEPTH    = 16,
    parameter int NUM_FU       = 2,
    parameter int NUM_PHYS_REG = 128,
    parameter int NUM_FLAGS    = 4
) (
    input  wire logic   clk_i,
    input  wire logic   reset_n_i,
    rob_commit_if.slave rob
);
    localparam int TAG_W  = $clog2(ROB_DEPTH);
    localparam int PHYS_W = $clog2(NUM_PHYS_REG);
    localparam int CNT_W  = TAG_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(ROB_DEPTH);

    // Per-entry state
    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_done;
    logic                 r_old_phys_v [ROB_DEPTH];
    logic [PHYS_W-1:0]    r_old_phys   [ROB_DEPTH];
    logic [NUM_FLAGS-1:0] r_flag_mask  [ROB_DEPTH];
    logic [NUM_FLAGS-1:0] r_flag_val   [ROB_DEPTH];

    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [ROB_DEPTH-1:0] w_cmp_hit;
    logic [NUM_FLAGS-1:0] w_cmp_flags [ROB_DEPTH];
    logic                 w_head_done;
    logic [NUM_FLAGS-1:0] w_head_val;
    logic                 w_commit;
    logic                 w_disp_ready;
    logic                 w_disp_fire;

    // Completion decode per entry. Ports are scanned in ascending order so
    // the highest-numbered port hitting an entry supplies its flag values.
    // Non-busy entries ignore completions entirely.
    always_comb begin
        for (int e = 0; e < ROB_DEPTH; e++) begin
            w_cmp_hit[e]   = 1'b0;
            w_cmp_flags[e] = r_flag_val[e];
            for (int p = 0; p < NUM_FU; p++) begin
                if (rob.cmp_v_i[p] && r_busy[e] &&
                    (rob.cmp_tag_i[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    w_cmp_hit[e]   = 1'b1;
                    w_cmp_flags[e] = rob.cmp_flags_i[p*NUM_FLAGS +: NUM_FLAGS];
                end
            end
        end
    end

`ifdef ROB_CMP_BYPASS_EN
    // A same-cycle completion of the head counts as done and supplies flags.
    assign w_head_done = r_done[r_head] | w_cmp_hit[r_head];
    assign w_head_val  = w_cmp_flags[r_head];
`else
    assign w_head_done = r_done[r_head];
    assign w_head_val  = r_flag_val[r_head];
`endif

    // Flush suppresses commit; an empty buffer has busy[head]=0.
    assign w_commit     = r_busy[r_head] & w_head_done & ~rob.flush_i;
    // Readiness ignores a same-cycle commit so a full buffer never accepts.
    assign w_disp_ready = (r_count != c_full);
    assign w_disp_fire  = rob.disp_v_i & w_disp_ready & ~rob.flush_i;

    assign rob.disp_ready_o      = w_disp_ready;
    assign rob.disp_tag_o        = r_tail;
    assign rob.commit_v_o        = w_commit;
    assign rob.commit_tag_o      = r_head;
    assign rob.rob_count_o       = r_count;
    assign rob.rob_phys_valid_o  = w_commit & r_old_phys_v[r_head];
    assign rob.rob_phys_reg_cl_o = r_old_phys[r_head];
    assign rob.rob_flag_valid_o  = w_commit & (|r_flag_mask[r_head]);
    // Gated so stale head contents never appear while nothing retires.
    assign rob.rob_flag_o        = w_commit ?
                                   {r_flag_mask[r_head], w_head_val & r_flag_mask[r_head]} :
                                   '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || rob.flush_i) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (w_cmp_hit[e]) begin
                    r_done[e]     <= 1'b1;
                    r_flag_val[e] <= w_cmp_flags[e];
                end
            end
            // Retirement clears the head after any completion update above.
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + TAG_W'(1);
            end
            // Tail never equals a retiring head (that needs empty or full).
            if (w_disp_fire) begin
                r_busy[r_tail]       <= 1'b1;
                r_done[r_tail]       <= 1'b0;
                r_old_phys_v[r_tail] <= rob.disp_old_phys_v_i;
                r_old_phys[r_tail]   <= rob.disp_old_phys_i;
                r_flag_mask[r_tail]  <= rob.disp_flag_mask_i;
                r_tail               <= r_tail + TAG_W'(1);
            end
            r_count <= r_count + CNT_W'(w_disp_fire) - CNT_W'(w_commit);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_commit
// Purpose  : Self-checking bench for rob_commit: vector table, directed
//            multi-cycle sequences and randomized traffic against a
//            queue-based reference model of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_commit;
`ifdef ROB_CMP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    rob_commit_if #(.ROB_DEPTH(16), .NUM_FU(2), .NUM_PHYS_REG(128), .NUM_FLAGS(4)) bus ();

    rob_commit #(.ROB_DEPTH(16), .NUM_FU(2), .NUM_PHYS_REG(128), .NUM_FLAGS(4)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .rob       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: age-ordered queue ----------------
    typedef struct {
        int tag;
        bit oldv;
        int old;
        int mask;
        int val;
        bit done;
    } ent_t;
    ent_t mq[$];
    int   m_head;

    typedef struct {
        bit       dv;
        bit       opv;
        int       op;
        int       mask;
        bit [1:0] cv;
        int       t0, t1, f0, f1;
        bit       fl;
        int       ecv, ectag, ecnt, etag, epv, epreg, efv, eflag;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(bit dv, bit opv, int op, int mask, bit [1:0] cv,
                          int t0, int t1, int f0, int f1, bit fl);
        bus.disp_v_i          = dv;
        bus.disp_old_phys_v_i = opv;
        bus.disp_old_phys_i   = 7'(op);
        bus.disp_flag_mask_i  = 4'(mask);
        bus.cmp_v_i           = cv;
        bus.cmp_tag_i         = {4'(t1), 4'(t0)};
        bus.cmp_flags_i       = {4'(f1), 4'(f0)};
        bus.flush_i           = fl;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        mq.delete();
        m_head = 0;
    endtask

    function automatic vec_t mk(bit dv, bit opv, int op, int mask, bit [1:0] cv,
                                int t0, int t1, int f0, int f1, bit fl,
                                int ecv, int ectag, int ecnt, int etag,
                                int epv, int epreg, int efv, int eflag);
        vec_t v;
        v.dv = dv; v.opv = opv; v.op = op; v.mask = mask; v.cv = cv;
        v.t0 = t0; v.t1 = t1; v.f0 = f0; v.f1 = f1; v.fl = fl;
        v.ecv = ecv; v.ectag = ectag; v.ecnt = ecnt; v.etag = etag;
        v.epv = epv; v.epreg = epreg; v.efv = efv; v.eflag = eflag;
        return v;
    endfunction

    // Compare current outputs to the model, then advance the model by the
    // cycle's inputs as the clock edge will.
    task automatic model_cycle(bit dv, bit opv, int op, int mask, bit [1:0] cv,
                               int t0, int t1, int f0, int f1, bit fl);
        int n, etag, eval, emask;
        bit ecv;
        int tg[2];
        int fg[2];
        ent_t ne;
        tg[0] = t0; tg[1] = t1; fg[0] = f0; fg[1] = f1;
        n    = mq.size();
        etag = (m_head + n) % 16;
        chk("rnd rdy",   int'(bus.disp_ready_o), (n != 16) ? 1 : 0);
        chk("rnd tag",   int'(bus.disp_tag_o),   etag);
        chk("rnd cnt",   int'(bus.rob_count_o),  n);
        chk("rnd ctag",  int'(bus.commit_tag_o), m_head);
        ecv = 1'b0; eval = 0; emask = 0;
        if (n > 0) begin
            eval  = mq[0].val;
            emask = mq[0].mask;
            ecv   = mq[0].done;
            if (BYP) begin
                for (int p = 0; p < 2; p++) begin
                    if (cv[p] && tg[p] == mq[0].tag) begin
                        ecv  = 1'b1;
                        eval = fg[p];
                    end
                end
            end
            if (fl) ecv = 1'b0;
        end
        chk("rnd cv", int'(bus.commit_v_o), int'(ecv));
        if (ecv) begin
            chk("rnd pv", int'(bus.rob_phys_valid_o), int'(mq[0].oldv));
            if (mq[0].oldv) chk("rnd preg", int'(bus.rob_phys_reg_cl_o), mq[0].old);
            chk("rnd fv",   int'(bus.rob_flag_valid_o), (emask != 0) ? 1 : 0);
            chk("rnd flag", int'(bus.rob_flag_o), emask * 16 + (eval & emask));
        end else begin
            chk("rnd pv idle",   int'(bus.rob_phys_valid_o), 0);
            chk("rnd fv idle",   int'(bus.rob_flag_valid_o), 0);
            chk("rnd flag idle", int'(bus.rob_flag_o), 0);
        end
        if (fl) begin
            mq.delete();
            m_head = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (cv[p]) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].tag == tg[p]) begin
                            mq[i].done = 1'b1;
                            mq[i].val  = fg[p];
                        end
                    end
                end
            end
            if (ecv) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % 16;
            end
            if (dv && n != 16) begin
                ne.tag = etag; ne.oldv = opv; ne.old = op; ne.mask = mask;
                ne.val = 0; ne.done = 1'b0;
                mq.push_back(ne);
            end
        end
    endtask

    function automatic int pick_tag();
        if (mq.size() > 0 && $urandom_range(9) < 8)
            return mq[$urandom_range(mq.size() - 1)].tag;
        return int'($urandom_range(15));
    endfunction

    initial begin
        int b, nb, got;
        int ctags[$];
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        b  = BYP ? 1 : 0;
        nb = 1 - b;

        // ---------------- reset state ----------------
        do_reset();
        chk("reset rdy",  int'(bus.disp_ready_o), 1);
        chk("reset tag",  int'(bus.disp_tag_o), 0);
        chk("reset cv",   int'(bus.commit_v_o), 0);
        chk("reset pv",   int'(bus.rob_phys_valid_o), 0);
        chk("reset fv",   int'(bus.rob_flag_valid_o), 0);
        chk("reset flag", int'(bus.rob_flag_o), 0);
        chk("reset ctag", int'(bus.commit_tag_o), 0);
        chk("reset cnt",  int'(bus.rob_count_o), 0);

        // ---------------- vector table ----------------
        //           dv opv op    mask cv    t0 t1 f0   f1 fl | ecv ectag ecnt etag epv epreg efv eflag
        tbl[0]  = mk(1, 1, 'h25, 3,    2'b00, 0, 0, 0,   0, 0,  0,  0,        0,       0, 0,  0,    0,  0);
        tbl[1]  = mk(0, 0, 0,    0,    2'b01, 0, 0, 'hE, 0, 0,  b,  0,        1,       1, b,  'h25, b,  b ? 'h32 : 0);
        tbl[2]  = mk(0, 0, 0,    0,    2'b00, 0, 0, 0,   0, 0,  nb, b,        nb,      1, nb, 'h25, nb, b ? 0 : 'h32);
        tbl[3]  = mk(0, 0, 0,    0,    2'b00, 0, 0, 0,   0, 0,  0,  1,        0,       1, 0,  0,    0,  0);
        tbl[4]  = mk(1, 0, 0,    0,    2'b00, 0, 0, 0,   0, 0,  0,  1,        0,       1, 0,  0,    0,  0);
        tbl[5]  = mk(1, 0, 0,    0,    2'b00, 0, 0, 0,   0, 0,  0,  1,        1,       2, 0,  0,    0,  0);
        tbl[6]  = mk(1, 1, 'h7F, 'hF,  2'b00, 0, 0, 0,   0, 0,  0,  1,        2,       3, 0,  0,    0,  0);
        tbl[7]  = mk(0, 0, 0,    0,    2'b11, 1, 2, 5,   5, 0,  b,  1,        3,       4, 0,  0,    0,  0);
        tbl[8]  = mk(0, 0, 0,    0,    2'b11, 3, 3, 1,   8, 0,  1,  b ? 2 : 1, b ? 2 : 3, 4, 0,  0,    0,  0);
        tbl[9]  = mk(0, 0, 0,    0,    2'b00, 0, 0, 0,   0, 0,  1,  b ? 3 : 2, b ? 1 : 2, 4, b,  'h7F, b,  b ? 'hF8 : 0);
        tbl[10] = mk(0, 0, 0,    0,    2'b00, 0, 0, 0,   0, 0,  nb, b ? 4 : 3, nb,      4, nb, 'h7F, nb, b ? 0 : 'hF8);
        tbl[11] = mk(0, 0, 0,    0,    2'b00, 0, 0, 0,   0, 0,  0,  4,        0,       4, 0,  0,    0,  0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(tbl[i].dv, tbl[i].opv, tbl[i].op, tbl[i].mask, tbl[i].cv,
                   tbl[i].t0, tbl[i].t1, tbl[i].f0, tbl[i].f1, tbl[i].fl);
            #2;
            chk($sformatf("v%0d cv", i),   int'(bus.commit_v_o),       tbl[i].ecv);
            chk($sformatf("v%0d ctag", i), int'(bus.commit_tag_o),     tbl[i].ectag);
            chk($sformatf("v%0d cnt", i),  int'(bus.rob_count_o),      tbl[i].ecnt);
            chk($sformatf("v%0d tag", i),  int'(bus.disp_tag_o),       tbl[i].etag);
            chk($sformatf("v%0d pv", i),   int'(bus.rob_phys_valid_o), tbl[i].epv);
            if (tbl[i].epv != 0)
                chk($sformatf("v%0d preg", i), int'(bus.rob_phys_reg_cl_o), tbl[i].epreg);
            chk($sformatf("v%0d fv", i),   int'(bus.rob_flag_valid_o), tbl[i].efv);
            chk($sformatf("v%0d flag", i), int'(bus.rob_flag_o),       tbl[i].eflag);
        end

        // ---------------- out-of-order completion, in-order commit ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (k)
                0:       set_in(0, 0, 0, 0, 2'b01, 2, 0, 0, 0, 0);
                1:       set_in(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
                2:       set_in(0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0);
                default: set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
            endcase
            #2;
            if (bus.commit_v_o) ctags.push_back(int'(bus.commit_tag_o));
        end
        chk("ooo commits", ctags.size(), 3);
        for (int i = 0; i < ctags.size() && i < 3; i++)
            chk($sformatf("ooo order %0d", i), ctags[i], i);

        // ---------------- full buffer ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        set_in(1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
        #2;
        chk("full rdy",  int'(bus.disp_ready_o), 0);
        chk("full cnt",  int'(bus.rob_count_o), 16);
        chk("full tag",  int'(bus.disp_tag_o), 0);
        chk("full cv",   int'(bus.commit_v_o), b);
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            @(negedge clk);
            set_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
            #2;
            if (bus.disp_ready_o) begin
                got = 1;
                chk("full drain cnt", int'(bus.rob_count_o), 15);
                chk("full wrap tag",  int'(bus.disp_tag_o), 0);
            end else begin
                chk("full refused cnt", int'(bus.rob_count_o), 16);
            end
        end
        chk("full wait", got, 1);
        @(negedge clk);
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #2;
        chk("full refill cnt", int'(bus.rob_count_o), 16);
        chk("full refill tag", int'(bus.disp_tag_o), 1);
        chk("full refill rdy", int'(bus.disp_ready_o), 0);

        // Mid-operation reset drops everything.
        do_reset();
        chk("rst mid cnt",  int'(bus.rob_count_o), 0);
        chk("rst mid rdy",  int'(bus.disp_ready_o), 1);
        chk("rst mid ctag", int'(bus.commit_tag_o), 0);
        chk("rst mid cv",   int'(bus.commit_v_o), 0);

        // ---------------- flush ----------------
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1, 1, i + 1, 'hF, 2'b00, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 2'b11, 1, 2, 3, 3, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 2'b11, 3, 4, 3, 3, 0);
        @(negedge clk);
        set_in(1, 1, 9, 'hF, 2'b01, 0, 0, 'hF, 0, 1);
        #2;
        chk("flush cv", int'(bus.commit_v_o), 0);
        chk("flush pv", int'(bus.rob_phys_valid_o), 0);
        chk("flush fv", int'(bus.rob_flag_valid_o), 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #2;
        chk("post flush cnt",  int'(bus.rob_count_o), 0);
        chk("post flush tag",  int'(bus.disp_tag_o), 0);
        chk("post flush ctag", int'(bus.commit_tag_o), 0);
        chk("post flush rdy",  int'(bus.disp_ready_o), 1);
        chk("post flush cv",   int'(bus.commit_v_o), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        end
        #2;
        chk("post flush stale cnt", int'(bus.rob_count_o), 1);
        chk("post flush stale cv",  int'(bus.commit_v_o), 0);

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit       dv, opv, fl;
            int       op, mask, t0, t1, f0, f1;
            bit [1:0] cv;
            @(negedge clk);
            dv   = ($urandom_range(9) < 6);
            opv  = $urandom_range(1) == 1;
            op   = int'($urandom_range(127));
            mask = int'($urandom_range(15));
            cv   = 2'($urandom_range(3));
            t0   = pick_tag();
            t1   = pick_tag();
            f0   = int'($urandom_range(15));
            f1   = int'($urandom_range(15));
            fl   = ($urandom_range(99) < 2);
            set_in(dv, opv, op, mask, cv, t0, t1, f0, f1, fl);
            #2;
            model_cycle(dv, opv, op, mask, cv, t0, t1, f0, f1, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
